// File: rtl/parity_pkg.sv
// Shared types and helpers for the serial parity-check receiver.
package parity_pkg;

  localparam int unsigned StateW = 2;

  localparam logic [StateW-1:0] EncIdle = 2'd0;
  localparam logic [StateW-1:0] EncData = 2'd1;
  localparam logic [StateW-1:0] EncPar  = 2'd2;

  typedef enum logic [StateW-1:0] {
    StIdle = EncIdle,
    StData = EncData,
    StPar  = EncPar
  } state_e;

  // Bit counter must hold 0..width inclusive.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/parity_check_rx_if.sv
// Serial-in / word-out bundle of the parity-check receiver.
interface parity_check_rx_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
);

  logic             sin;
  logic             svalid;
  logic             sstart;
  logic             clr_cnt;
  logic [WIDTH-1:0] dout;
  logic             dvalid;
  logic             perr;
  logic             frm_err;
  logic [CNT_W-1:0] errcnt;

  modport master (
    output sin, svalid, sstart, clr_cnt,
    input  dout, dvalid, perr, frm_err, errcnt
  );

  modport slave (
    input  sin, svalid, sstart, clr_cnt,
    output dout, dvalid, perr, frm_err, errcnt
  );

endinterface

// File: rtl/parity_sat_counter.sv
// Saturating up-counter with synchronous clear that beats a coincident increment.
module parity_sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/parity_check_rx.sv
// Serial parity-check receiver: deserialises WIDTH data bits LSB-first plus a parity bit,
// flags parity mismatches and aborted frames, and counts bad frames.
module parity_check_rx
  import parity_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter bit          ODD   = 1'b0,
  parameter int unsigned CNT_W = 8
) (
  input logic              clk,
  input logic              rst,
  parity_check_rx_if.slave bus
);

  localparam int unsigned CntBits = cnt_width(WIDTH);

  state_e               state_q, state_d;
  logic [CntBits-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]     shift_q, shift_d;
  logic                 par_q, par_d;
  logic [WIDTH-1:0]     dout_q, dout_d;
  logic                 dvalid_q, dvalid_d;
  logic                 perr_q, perr_d;
  logic                 frm_q, frm_d;
  logic                 err_inc;
  logic [CNT_W-1:0]     errcnt;
  logic [WIDTH-1:0]     shift_in;

  // Right-shifting insertion lands the first of WIDTH bits at bit 0.
  assign shift_in = (shift_q >> 1) | (WIDTH'(bus.sin) << (WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    dout_d   = dout_q;
    dvalid_d = 1'b0;
    perr_d   = 1'b0;
    frm_d    = 1'b0;
    err_inc  = 1'b0;

    if (bus.svalid) begin
      if (bus.sstart) begin
        // A start in mid-frame aborts the partial word; SIN is bit 0 of the new one.
        frm_d   = (state_q != StIdle);
        shift_d = shift_in;
        par_d   = bus.sin;
        cnt_d   = CntBits'(1);
        state_d = (WIDTH == 1) ? StPar : StData;
      end else begin
        unique case (state_q)
          StIdle: ;
          StData: begin
            shift_d = shift_in;
            par_d   = par_q ^ bus.sin;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CntBits'(WIDTH - 1)) begin
              state_d = StPar;
            end
          end
          StPar: begin
            dvalid_d = 1'b1;
            perr_d   = ((par_q ^ bus.sin) != ODD);
            err_inc  = perr_d;
            dout_d   = shift_q;
            par_d    = 1'b0;
            cnt_d    = '0;
            state_d  = StIdle;
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      perr_q   <= 1'b0;
      frm_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      perr_q   <= perr_d;
      frm_q    <= frm_d;
    end
  end

  parity_sat_counter #(
    .CNT_W(CNT_W)
  ) u_errcnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_inc),
    .clr   (bus.clr_cnt),
    .count (errcnt)
  );

  assign bus.dout    = dout_q;
  assign bus.dvalid  = dvalid_q;
  assign bus.perr    = perr_q;
  assign bus.frm_err = frm_q;
  assign bus.errcnt  = errcnt;

endmodule
